// File: rtl/mul_result_buffer.sv
// Result FIFO behind the combinational multiplier: stores {Overf, Result} with
// precomputed Z/N/V flags and keeps a sticky overflow indication.
module mul_result_buffer #(
    parameter int N     = 4,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N-1:0]             in_result,
    input  logic [N-1:0]             in_overf,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [N-1:0]             out_result,
    output logic [N-1:0]             out_overf,
    output logic                     out_z,
    output logic                     out_n,
    output logic                     out_v,
    output logic                     sticky_v,
    input  logic                     clr_sticky,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [N-1:0] overf;
        logic [N-1:0] result;
        logic         z;
        logic         n;
        logic         v;
    } entry_t;

    entry_t          mem_q [DEPTH];
    entry_t          mem_d [DEPTH];
    logic [PW-1:0]   wptr_q, wptr_d;
    logic [PW-1:0]   rptr_q, rptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            sticky_q, sticky_d;

    logic            full, empty;
    logic            wr_en, rd_en;
    entry_t          new_entry;
    entry_t          head;

    // Ready/valid depend only on registered occupancy, so there is no
    // combinational path from out_ready to in_ready.
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign wr_en = in_valid & ~full;
    assign rd_en = out_ready & ~empty;

    always_comb begin
        new_entry.overf  = in_overf;
        new_entry.result = in_result;
        new_entry.z      = ({in_overf, in_result} == '0);
        new_entry.n      = in_overf[N-1];
        new_entry.v      = |in_overf;
    end

    always_comb begin
        mem_d    = mem_q;
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        count_d  = count_q;
        sticky_d = sticky_q;

        if (wr_en) begin
            mem_d[wptr_q] = new_entry;
            wptr_d        = wptr_q + PW'(1);
        end
        if (rd_en) begin
            rptr_d = rptr_q + PW'(1);
        end

        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // A V=1 write in the same cycle as a clear leaves the flag set.
        if (clr_sticky) begin
            sticky_d = 1'b0;
        end
        if (wr_en && new_entry.v) begin
            sticky_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            sticky_q <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            sticky_q <= sticky_d;
        end
    end

    // Storage is not reset; stale contents are hidden by the empty mask.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_comb begin
        head       = mem_q[rptr_q];
        out_result = empty ? '0   : head.result;
        out_overf  = empty ? '0   : head.overf;
        out_z      = empty ? 1'b0 : head.z;
        out_n      = empty ? 1'b0 : head.n;
        out_v      = empty ? 1'b0 : head.v;
    end

    assign in_ready  = ~full;
    assign out_valid = ~empty;
    assign sticky_v  = sticky_q;
    assign count     = count_q;

endmodule
